// File: rtl/arb_req_ctrl.sv
// Upstream request stage for the two-client arbiter: accepts one burst command per client,
// holds req until all beats are granted, and flags starvation and grant-protocol errors.
module arb_req_ctrl #(
  parameter int unsigned LenW      = 4,
  parameter int unsigned StarveLim = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd0_valid_i,
  output logic            cmd0_ready_o,
  input  logic [LenW-1:0] cmd0_len_i,
  input  logic            cmd1_valid_i,
  output logic            cmd1_ready_o,
  input  logic [LenW-1:0] cmd1_len_i,
  output logic            req0_o,
  output logic            req1_o,
  input  logic            gnt0_i,
  input  logic            gnt1_i,
  output logic            beat0_o,
  output logic            beat1_o,
  output logic            last0_o,
  output logic            last1_o,
  output logic            starve0_o,
  output logic            starve1_o,
  output logic            err_gnt_o
);

  localparam int unsigned StW = $clog2(StarveLim + 1);
  localparam logic [StW-1:0] WaitLim = StW'(StarveLim);
  localparam logic [StW-1:0] WaitSet = StW'(StarveLim - 1);

  typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

  logic [1:0]      cmd_valid;
  logic [1:0]      gnt;
  logic [1:0]      beat;
  logic [1:0]      last;
  logic [1:0]      ready;
  logic [1:0]      req;
  logic [1:0]      starve;
  logic [1:0]      idle_gnt;
  logic [LenW-1:0] cmd_len [2];
  logic            gnt_both;
  logic            err_q;

  assign cmd_valid  = {cmd1_valid_i, cmd0_valid_i};
  assign gnt        = {gnt1_i, gnt0_i};
  assign cmd_len[0] = cmd0_len_i;
  assign cmd_len[1] = cmd1_len_i;
  assign gnt_both   = gnt[0] & gnt[1];

  for (genvar n = 0; n < 2; n++) begin : g_client
    state_e          state_q;
    logic [LenW-1:0] cnt_q;
    logic [StW-1:0]  wait_q;
    logic            started_q;
    logic            req_q;
    logic            ready_q;
    logic            starve_q;

    // A collision cycle is treated as a stall for both clients.
    assign beat[n]     = (state_q == StReq) & gnt[n] & ~gnt_both;
    assign last[n]     = beat[n] & (cnt_q == '0);
    assign idle_gnt[n] = (state_q == StIdle) & gnt[n];
    assign ready[n]    = ready_q;
    assign req[n]      = req_q;
    assign starve[n]   = starve_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        wait_q    <= '0;
        started_q <= 1'b0;
        req_q     <= 1'b0;
        ready_q   <= 1'b1;
        starve_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd_valid[n]) begin
              cnt_q     <= cmd_len[n];
              wait_q    <= '0;
              started_q <= 1'b0;
              req_q     <= 1'b1;
              ready_q   <= 1'b0;
              state_q   <= StReq;
            end
          end
          StReq: begin
            if (beat[n]) begin
              started_q <= 1'b1;
              wait_q    <= '0;
              if (last[n]) begin
                req_q   <= 1'b0;
                state_q <= StRel;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end else if (!started_q && (wait_q != WaitLim)) begin
              wait_q <= wait_q + 1'b1;
              if (wait_q == WaitSet) begin
                starve_q <= 1'b1;
              end
            end
          end
          StRel: begin
            // Wait for the arbiter to drop its grant before taking a new command.
            if (!gnt[n]) begin
              ready_q <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (gnt_both || (idle_gnt != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  a_beat_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(beat[0] && beat[1]));

  assign cmd0_ready_o = ready[0];
  assign cmd1_ready_o = ready[1];
  assign req0_o       = req[0];
  assign req1_o       = req[1];
  assign beat0_o      = beat[0];
  assign beat1_o      = beat[1];
  assign last0_o      = last[0];
  assign last1_o      = last[1];
  assign starve0_o    = starve[0];
  assign starve1_o    = starve[1];
  assign err_gnt_o    = err_q;

endmodule
